// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the execute-stage DIV sequencer and the iterative divider.
interface div_issue_ctrl_if;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    modport master (
        output div_start_o,
        output div_signed_o,
        output div_op1_o,
        output div_op2_o,
        output div_annul_o,
        input  div_result_i,
        input  div_ready_i
    );

    modport slave (
        input  div_start_o,
        input  div_signed_o,
        input  div_op1_o,
        input  div_op2_o,
        input  div_annul_o,
        output div_result_i,
        output div_ready_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage DIV/DIVU sequencer: issues operands to the iterative divider, stalls the
// pipeline until the result returns, writes HI/LO once, and drains the divider after a flush.
module div_issue_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_div_valid,
    input  logic                    ex_div_signed,
    input  logic [31:0]             ex_rs,
    input  logic [31:0]             ex_rt,
    input  logic                    ex_stall_i,
    input  logic                    flush,
    div_issue_ctrl_if.master        div_if,
    output logic                    stall_req_o,
    output logic                    hilo_we_o,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t      state_r,     state_nxt_s;
    logic        abort_cnt_r, abort_cnt_nxt_s;
    logic        start_r,     start_nxt_s;
    logic        signed_r,    signed_nxt_s;
    logic [31:0] op1_r,       op1_nxt_s;
    logic [31:0] op2_r,       op2_nxt_s;
    logic        annul_r,     annul_nxt_s;
    logic [31:0] hi_r,        hi_nxt_s;
    logic [31:0] lo_r,        lo_nxt_s;
    logic        we_flag_r,   we_flag_nxt_s;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            abort_cnt_r <= 1'b0;
            start_r     <= 1'b0;
            signed_r    <= 1'b0;
            op1_r       <= 32'd0;
            op2_r       <= 32'd0;
            annul_r     <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            we_flag_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            abort_cnt_r <= abort_cnt_nxt_s;
            start_r     <= start_nxt_s;
            signed_r    <= signed_nxt_s;
            op1_r       <= op1_nxt_s;
            op2_r       <= op2_nxt_s;
            annul_r     <= annul_nxt_s;
            hi_r        <= hi_nxt_s;
            lo_r        <= lo_nxt_s;
            we_flag_r   <= we_flag_nxt_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        abort_cnt_nxt_s = abort_cnt_r;
        start_nxt_s     = start_r;
        signed_nxt_s    = signed_r;
        op1_nxt_s       = op1_r;
        op2_nxt_s       = op2_r;
        annul_nxt_s     = 1'b0;
        hi_nxt_s        = hi_r;
        lo_nxt_s        = lo_r;
        we_flag_nxt_s   = we_flag_r;

        case (state_r)
            ST_IDLE: begin
                if (ex_div_valid && !flush) begin
                    op1_nxt_s    = ex_rs;
                    op2_nxt_s    = ex_rt;
                    signed_nxt_s = ex_div_signed;
                    start_nxt_s  = 1'b1;
                    state_nxt_s  = ST_BUSY;
                end else begin
                    start_nxt_s  = 1'b0;
                end
            end
            ST_BUSY: begin
                // Operands stay frozen; the divider re-reads them for sign correction.
                if (flush) begin
                    annul_nxt_s     = 1'b1;
                    start_nxt_s     = 1'b0;
                    abort_cnt_nxt_s = 1'b0;
                    state_nxt_s     = ST_ABORT;
                end else if (div_if.div_ready_i) begin
                    hi_nxt_s      = div_if.div_result_i[63:32];
                    lo_nxt_s      = div_if.div_result_i[31:0];
                    we_flag_nxt_s = 1'b1;
                    start_nxt_s   = 1'b0;
                    state_nxt_s   = ST_DONE;
                end else begin
                    state_nxt_s   = ST_BUSY;
                end
            end
            ST_DONE: begin
                we_flag_nxt_s = 1'b0;
                if (!ex_stall_i || flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ABORT: begin
                start_nxt_s = 1'b0;
                if (abort_cnt_r == 1'b1) begin
                    abort_cnt_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    abort_cnt_nxt_s = 1'b1;
                    state_nxt_s     = ST_ABORT;
                end
            end
            default: begin
                start_nxt_s     = 1'b0;
                we_flag_nxt_s   = 1'b0;
                abort_cnt_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    assign stall_req_o = ((state_r == ST_IDLE) && ex_div_valid && !flush)
                       || (state_r == ST_BUSY)
                       || (state_r == ST_ABORT);

    // A flush landing on the DONE cycle suppresses the HI/LO write.
    assign hilo_we_o = we_flag_r && !flush;
    assign hi_o      = hi_r;
    assign lo_o      = lo_r;

    assign div_if.div_start_o  = start_r;
    assign div_if.div_signed_o = signed_r;
    assign div_if.div_op1_o    = op1_r;
    assign div_if.div_op2_o    = op2_r;
    assign div_if.div_annul_o  = annul_r;

endmodule
